// File: rtl/fp_normalizer_if.sv
// rtl/fp_normalizer_if.sv - start/valid handshake bundle between the add/sub datapath, normalizer and rounder
interface fp_normalizer_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int W = MANT_W + 5;

  logic             i_start;
  logic [W-1:0]     i_sig;
  logic [EXP_W-1:0] i_exp;
  logic             i_sign;
  logic             o_busy;
  logic             o_valid;
  logic [W-1:0]     o_sig;
  logic [EXP_W-1:0] o_exp;
  logic             o_sign;
  logic             o_zero;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_start, i_sig, i_exp, i_sign,
    input  o_busy, o_valid, o_sig, o_exp, o_sign, o_zero, o_overflow, o_underflow
  );

  modport slave (
    input  i_start, i_sig, i_exp, i_sign,
    output o_busy, o_valid, o_sig, o_exp, o_sign, o_zero, o_overflow, o_underflow
  );
endinterface

// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - post-operation significand normalizer with bounded per-cycle left shift
module fp_normalizer #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int STEP   = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  fp_normalizer_if.slave bus
);
  localparam int W  = MANT_W + 5;
  localparam int RW = $clog2(W) + 1;
  localparam int CW = ((EXP_W > RW) ? EXP_W : RW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

  state_t           state;
  logic [W-1:0]     sig_r;
  logic [EXP_W-1:0] exp_r;
  logic             sign_r;
  logic             unf_r;
  logic [RW-1:0]    rem_r;

  logic             busy_r;
  logic             valid_r;
  logic [W-1:0]     out_sig_r;
  logic [EXP_W-1:0] out_exp_r;
  logic             out_sign_r;
  logic             out_zero_r;
  logic             out_ovf_r;
  logic             out_unf_r;

  logic [RW-1:0]    lz;
  logic [W-1:0]     chk_sig;
  logic [EXP_W-1:0] chk_exp;
  logic [RW-1:0]    chk_rem;
  logic             chk_zero;
  logic             chk_ovf;
  logic             chk_unf;
  logic [RW-1:0]    amt;
  logic [W-1:0]     sig_shl;

  function automatic logic [RW-1:0] count_lz(input logic [W-2:0] v);
    count_lz = RW'(W - 1);
    for (int i = 0; i < W - 1; i++) begin
      if (v[i]) count_lz = RW'(W - 2 - i);
    end
  endfunction

  // Classification of the latched operand; only the registered sig feeds lz.
  always_comb begin
    lz       = count_lz(sig_r[W-2:0]);
    chk_sig  = sig_r;
    chk_exp  = exp_r;
    chk_rem  = '0;
    chk_zero = 1'b0;
    chk_ovf  = 1'b0;
    chk_unf  = 1'b0;
    if (exp_r == '1) begin
      chk_sig = sig_r;
    end else if (sig_r == '0) begin
      chk_zero = 1'b1;
      chk_exp  = '0;
    end else if (sig_r[W-1]) begin
      chk_sig = {1'b0, sig_r[W-1:2], sig_r[1] | sig_r[0]};
      chk_exp = exp_r + EXP_W'(1);
      if (chk_exp == '1) begin
        chk_ovf = 1'b1;
        chk_sig = '0;
      end
    end else if (CW'(lz) < CW'(exp_r)) begin
      chk_rem = lz;
      chk_exp = EXP_W'(CW'(exp_r) - CW'(lz));
    end else begin
      // Exponent runs out first: stop at the subnormal boundary.
      chk_rem = RW'(CW'(exp_r) - CW'(1));
      chk_exp = '0;
      chk_unf = 1'b1;
    end
  end

  always_comb begin
    amt     = (rem_r < RW'(STEP)) ? rem_r : RW'(STEP);
    sig_shl = sig_r << amt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      sig_r      <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      unf_r      <= 1'b0;
      rem_r      <= '0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      out_sig_r  <= '0;
      out_exp_r  <= '0;
      out_sign_r <= 1'b0;
      out_zero_r <= 1'b0;
      out_ovf_r  <= 1'b0;
      out_unf_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            sig_r  <= bus.i_sig;
            exp_r  <= (bus.i_exp == '0) ? EXP_W'(1) : bus.i_exp;
            sign_r <= bus.i_sign;
            unf_r  <= 1'b0;
            rem_r  <= '0;
            busy_r <= 1'b1;
            state  <= S_CHECK;
          end else begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (chk_rem == '0) begin
            out_sig_r  <= chk_sig;
            out_exp_r  <= chk_exp;
            out_sign_r <= sign_r;
            out_zero_r <= chk_zero;
            out_ovf_r  <= chk_ovf;
            out_unf_r  <= chk_unf;
            busy_r     <= 1'b0;
            valid_r    <= 1'b1;
            state      <= S_DONE;
          end else begin
            exp_r <= chk_exp;
            unf_r <= chk_unf;
            rem_r <= chk_rem;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sig_r <= sig_shl;
          rem_r <= rem_r - amt;
          if (rem_r == amt) begin
            out_sig_r  <= sig_shl;
            out_exp_r  <= exp_r;
            out_sign_r <= sign_r;
            out_zero_r <= 1'b0;
            out_ovf_r  <= 1'b0;
            out_unf_r  <= unf_r;
            busy_r     <= 1'b0;
            valid_r    <= 1'b1;
            state      <= S_DONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy      = busy_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_sig       = out_sig_r;
  assign bus.o_exp       = out_exp_r;
  assign bus.o_sign      = out_sign_r;
  assign bus.o_zero      = out_zero_r;
  assign bus.o_overflow  = out_ovf_r;
  assign bus.o_underflow = out_unf_r;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - self-checking bench for fp_normalizer
module tb_fp_normalizer;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int STEP   = 4;
  localparam int W      = MANT_W + 5;
  localparam int BUDGET = 60;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   total = 0;
  int   bad   = 0;

  fp_normalizer_if #(.EXP_W(EXP_W), .MANT_W(MANT_W)) bus ();

  fp_normalizer #(.EXP_W(EXP_W), .MANT_W(MANT_W), .STEP(STEP)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // Reference: integer arithmetic on the value, exponent counted in plain ints.
  task automatic model(input logic [W-1:0] s_in, input logic [EXP_W-1:0] e_in,
                       output logic [W-1:0] s_o, output logic [EXP_W-1:0] e_o,
                       output logic z, output logic ov, output logic un, output int lat);
    longint s, v;
    int e, lz, rem, emax;
    emax = (1 << EXP_W) - 1;
    s = longint'(s_in);
    e = (e_in == 0) ? 1 : int'(e_in);
    z = 0; ov = 0; un = 0; rem = 0;
    if (e == emax) begin
      rem = 0;
    end else if (s == 0) begin
      z = 1; e = 0;
    end else if (s >= (longint'(1) << (W - 1))) begin
      s = (s >> 1) | (s & 1);
      e = e + 1;
      if (e == emax) begin ov = 1; s = 0; end
    end else begin
      lz = 0; v = s;
      while (v < (longint'(1) << (W - 2))) begin v = v * 2; lz++; end
      if (lz < e) begin rem = lz; e = e - lz; end
      else begin rem = e - 1; e = 0; un = 1; end
      s = s << rem;
    end
    s_o = s[W-1:0];
    e_o = EXP_W'(e);
    lat = 2 + (rem + STEP - 1) / STEP;
  endtask

  task automatic run_op(input logic [W-1:0] s, input logic [EXP_W-1:0] e, input logic sg,
                        output int lat, output logic [W-1:0] gs, output logic [EXP_W-1:0] ge,
                        output logic [3:0] gf);
    bus.i_sig = s; bus.i_exp = e; bus.i_sign = sg; bus.i_start = 1'b1;
    lat = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge i_clk);
      if (n == 1) bus.i_start = 1'b0;
      if (bus.o_valid) begin lat = n; break; end
    end
    gs = bus.o_sig; ge = bus.o_exp;
    gf = {bus.o_sign, bus.o_zero, bus.o_overflow, bus.o_underflow};
  endtask

  task automatic test_reset();
    logic [W+EXP_W+5:0] obs;
    int vcount;
    i_rst_n = 1'b0;
    bus.i_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.i_sig = W'($urandom); bus.i_exp = EXP_W'($urandom); bus.i_sign = 1'($urandom);
      @(negedge i_clk);
      obs = {bus.o_busy, bus.o_valid, bus.o_sig, bus.o_exp, bus.o_sign,
             bus.o_zero, bus.o_overflow, bus.o_underflow};
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    end
    bus.i_start = 1'b0;
    i_rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (bus.o_valid) vcount++;
    end
    total++;
    if (vcount !== 0) begin bad++; $display("FAIL reset_no_valid got=%0d want=0", vcount); end
  endtask

  typedef struct {
    logic [W-1:0] s; logic [EXP_W-1:0] e;
    logic [W-1:0] xs; logic [EXP_W-1:0] xe; logic [3:0] xf; int xl;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    int lat; logic [W-1:0] gs; logic [EXP_W-1:0] ge; logic [3:0] gf;
    v[0] = '{28'h4000000, 8'd127, 28'h4000000, 8'd127, 4'b0000, 2};
    v[1] = '{28'h8000001, 8'd127, 28'h4000001, 8'd128, 4'b0000, 2};
    v[2] = '{28'h8000001, 8'd254, 28'h0000000, 8'd255, 4'b0010, 2};
    v[3] = '{28'h0000040, 8'd127, 28'h4000000, 8'd107, 4'b0000, 7};
    v[4] = '{28'h0000040, 8'd5,   28'h0000400, 8'd0,   4'b0001, 3};
    v[5] = '{28'h0000000, 8'd99,  28'h0000000, 8'd0,   4'b0100, 2};
    v[6] = '{28'h4000000, 8'd0,   28'h4000000, 8'd1,   4'b0000, 2};
    v[7] = '{28'h8000003, 8'd255, 28'h8000003, 8'd255, 4'b0000, 2};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].s, v[i].e, 1'b0, lat, gs, ge, gf);
      total++;
      if ({gs, ge, gf} !== {v[i].xs, v[i].xe, v[i].xf})
        begin bad++; $display("FAIL directed_%0d got=%h/%h/%b want=%h/%h/%b", i, gs, ge, gf, v[i].xs, v[i].xe, v[i].xf); end
      total++;
      if (lat !== v[i].xl) begin bad++; $display("FAIL directed_lat_%0d got=%0d want=%0d", i, lat, v[i].xl); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s, xs, gs; logic [EXP_W-1:0] e, xe, ge; logic sg, z, ov, un;
    logic [3:0] gf; int lat, xl, m;
    for (int i = 0; i < 300; i++) begin
      m = $urandom_range(0, 9);
      if (m == 0) s = '0;
      else if (m <= 2) s = {1'b1, (W-1)'($urandom)};
      else s = W'({1'b0, (W-1)'($urandom)} >> $urandom_range(0, W - 2));
      m = $urandom_range(0, 7);
      if (m == 0) e = '0;
      else if (m == 1) e = '1;
      else if (m == 2) e = EXP_W'(254);
      else if (m == 3) e = EXP_W'($urandom_range(1, 12));
      else e = EXP_W'($urandom);
      sg = 1'($urandom);
      model(s, e, xs, xe, z, ov, un, xl);
      run_op(s, e, sg, lat, gs, ge, gf);
      total++;
      if ({gs, ge, gf} !== {xs, xe, sg, z, ov, un})
        begin bad++; $display("FAIL random_%0d in=%h/%h got=%h/%h/%b want=%h/%h/%b", i, s, e, gs, ge, gf, xs, xe, {sg, z, ov, un}); end
      total++;
      if (lat !== xl) begin bad++; $display("FAIL random_lat_%0d in=%h/%h got=%0d want=%0d", i, s, e, lat, xl); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] gs; logic [EXP_W-1:0] ge; logic [3:0] gf;
    run_op(28'h0000040, 8'd127, 1'b1, lat, gs, ge, gf);
    // The next start lands on the DONE cycle of the previous operation.
    run_op(28'h8000001, 8'd127, 1'b0, lat, gs, ge, gf);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL b2b_lat got=%0d want=2", lat); end
    total++;
    if ({gs, ge, gf} !== {28'h4000001, 8'd128, 4'b0000})
      begin bad++; $display("FAIL b2b_result got=%h/%h/%b want=4000001/80/0000", gs, ge, gf); end
  endtask

  task automatic test_start_in_shift();
    int lat, extra;
    lat = -1; extra = 0;
    bus.i_sig = 28'h0000040; bus.i_exp = 8'd127; bus.i_sign = 1'b1; bus.i_start = 1'b1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge i_clk);
      if (n == 1) bus.i_start = 1'b0;
      if (n == 3) begin bus.i_sig = 28'h4000000; bus.i_exp = 8'd3; bus.i_sign = 1'b0; bus.i_start = 1'b1; end
      if (n == 4) bus.i_start = 1'b0;
      if (bus.o_valid) begin lat = n; break; end
    end
    total++;
    if (lat !== 7) begin bad++; $display("FAIL shift_start_lat got=%0d want=7", lat); end
    total++;
    if ({bus.o_sig, bus.o_exp, bus.o_sign} !== {28'h4000000, 8'd107, 1'b1})
      begin bad++; $display("FAIL shift_start_result got=%h/%h/%b want=4000000/6b/1", bus.o_sig, bus.o_exp, bus.o_sign); end
    for (int n = 0; n < 8; n++) begin
      @(negedge i_clk);
      if (bus.o_valid) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL shift_start_extra got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [W+EXP_W+5:0] obs;
    int vcount, lat; logic [W-1:0] gs; logic [EXP_W-1:0] ge; logic [3:0] gf;
    bus.i_sig = 28'h0000040; bus.i_exp = 8'd127; bus.i_sign = 1'b1; bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 obs = {bus.o_busy, bus.o_valid, bus.o_sig, bus.o_exp, bus.o_sign,
              bus.o_zero, bus.o_overflow, bus.o_underflow};
    total++;
    if (obs !== '0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", obs); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    vcount = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge i_clk);
      if (bus.o_valid) vcount++;
    end
    total++;
    if (vcount !== 0) begin bad++; $display("FAIL midreset_valid got=%0d want=0", vcount); end
    run_op(28'h0000040, 8'd5, 1'b0, lat, gs, ge, gf);
    total++;
    if ({lat, gs, ge, gf} !== {32'd3, 28'h0000400, 8'd0, 4'b0001})
      begin bad++; $display("FAIL midreset_after got=%0d/%h/%h/%b want=3/0000400/00/0001", lat, gs, ge, gf); end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_sig = '0; bus.i_exp = '0; bus.i_sign = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_in_shift();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
